// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared width, counter and Booth recoding constants for the multiplier.
package mul_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = $clog2(MUL_WIDTH + 2);

    localparam logic [1:0] BOOTH_NOP = 2'b00;
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mul_state_t;

endpackage

// File: rtl/mul_booth_if.sv
// rtl/mul_booth_if.sv - operand/product handshake bundle; is_signed exists only with MUL_UNSIGNED_EN.
interface mul_booth_if
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start;
`ifdef MUL_UNSIGNED_EN
    logic             is_signed;
`endif
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
`ifdef MUL_UNSIGNED_EN
        output is_signed,
`endif
        output a, b, start,
        input  hi, lo, busy, done
    );

    modport slave (
`ifdef MUL_UNSIGNED_EN
        input  is_signed,
`endif
        input  a, b, start,
        output hi, lo, busy, done
    );

endinterface

// File: rtl/mul_booth_step.sv
// rtl/mul_booth_step.sv - one radix-2 Booth iteration: add/sub multiplicand, then arithmetic shift right.
module mul_booth_step
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [WIDTH:0] i_acc,
    input  logic [WIDTH:0] i_mq,
    input  logic           i_q1,
    input  logic [WIDTH:0] i_mcand,
    output logic [WIDTH:0] o_acc,
    output logic [WIDTH:0] o_mq,
    output logic           o_q1
);

    logic [1:0]     w_op;
    logic [WIDTH:0] w_sum;

    always_comb begin
        w_op  = {i_mq[0], i_q1};
        w_sum = i_acc;
        case (w_op)
            BOOTH_ADD: w_sum = i_acc + i_mcand;
            BOOTH_SUB: w_sum = i_acc - i_mcand;
            default:   w_sum = i_acc;
        endcase
    end

    // Shift {sum, mq, q_1} right by one with the sign bit replicated.
    assign o_acc = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign o_mq  = {w_sum[0], i_mq[WIDTH:1]};
    assign o_q1  = i_mq[0];

endmodule

// File: rtl/mul_booth.sv
// rtl/mul_booth.sv - iterative radix-2 Booth multiplier top; MUL_UNSIGNED_EN adds the is_signed select.
module mul_booth
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic       clock,
    input  logic       resetn,
    mul_booth_if.slave bus
);

    localparam int                CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH);

    mul_state_t       r_state;
    mul_state_t       w_state_nxt;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH:0]   r_mq;
    logic             r_q1;
    logic [WIDTH:0]   r_mcand;
    logic [CNT_W-1:0] r_count;
    logic             r_done;

    logic             w_sign;
    logic             w_last;
    logic [WIDTH:0]   w_acc_nxt;
    logic [WIDTH:0]   w_mq_nxt;
    logic             w_q1_nxt;

`ifdef MUL_UNSIGNED_EN
    assign w_sign = bus.is_signed;
`else
    assign w_sign = 1'b1;
`endif

    mul_booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc   (r_acc),
        .i_mq    (r_mq),
        .i_q1    (r_q1),
        .i_mcand (r_mcand),
        .o_acc   (w_acc_nxt),
        .o_mq    (w_mq_nxt),
        .o_q1    (w_q1_nxt)
    );

    // A new start always wins, even over the final iteration of an older operation.
    always_comb begin
        w_state_nxt = r_state;
        w_last      = (r_count == CNT_LAST);
        if (bus.start) begin
            w_state_nxt = ST_BUSY;
        end else if (r_state == ST_BUSY && w_last) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_count <= '0;
            r_acc   <= '0;
            r_mq    <= '0;
            r_q1    <= 1'b0;
            r_mcand <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (bus.start) begin
                r_mcand <= {w_sign & bus.a[WIDTH-1], bus.a};
                r_mq    <= {w_sign & bus.b[WIDTH-1], bus.b};
                r_acc   <= '0;
                r_q1    <= 1'b0;
                r_count <= '0;
            end else if (r_state == ST_BUSY) begin
                r_acc   <= w_acc_nxt;
                r_mq    <= w_mq_nxt;
                r_q1    <= w_q1_nxt;
                r_count <= r_count + CNT_W'(1);
                if (w_last) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    // Product is the low 2*WIDTH bits of {acc, mq}.
    assign bus.hi   = {r_acc[WIDTH-2:0], r_mq[WIDTH]};
    assign bus.lo   = r_mq[WIDTH-1:0];
    assign bus.busy = (r_state == ST_BUSY);
    assign bus.done = r_done;

endmodule

// File: tb/tb_mul_booth.sv
// tb/tb_mul_booth.sv - directed vector bench for mul_booth; unsigned vectors run only with MUL_UNSIGNED_EN.
module tb_mul_booth;

    localparam int W = 32;

    logic clock  = 1'b0;
    logic resetn = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mul_booth_if #(.WIDTH(W)) bus ();

    mul_booth #(.WIDTH(W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        @(posedge clock);
        #1;
        bus.a     = a;
        bus.b     = b;
`ifdef MUL_UNSIGNED_EN
        bus.is_signed = sgn;
`else
        if (sgn !== 1'b1) $display("note: unsigned operand request ignored in signed-only build");
`endif
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Returns edges until done and the number of those samples where busy was high.
    task automatic wait_done(output int n, output int busy_n);
        n      = 0;
        busy_n = 0;
        while (n < 100) begin
            step();
            n++;
            if (bus.done === 1'b1) break;
            if (bus.busy === 1'b1) busy_n++;
        end
    endtask

    initial begin
        int n;
        int busy_n;
        int seen;

        bus.a     = '0;
        bus.b     = '0;
        bus.start = 1'b0;
`ifdef MUL_UNSIGNED_EN
        bus.is_signed = 1'b1;
`endif

        vecs.push_back('{32'h0000_0003, 32'h0000_0007, 1'b1, 32'h0000_0000, 32'h0000_0015});
        vecs.push_back('{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001});
        vecs.push_back('{32'h0000_0000, 32'h1234_5678, 1'b1, 32'h0000_0000, 32'h0000_0000});
        vecs.push_back('{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'h3FFF_FFFF, 32'h0000_0001});
        vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'hC000_0000, 32'h8000_0000});
        vecs.push_back('{32'h1234_5678, 32'h0000_0010, 1'b1, 32'h0000_0001, 32'h2345_6780});
        vecs.push_back('{32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{32'h8000_0000, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000});
`ifdef MUL_UNSIGNED_EN
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{32'h8000_0000, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 32'h0000_0006, 32'hFFFF_FFEB});
`endif

        repeat (2) step();
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_prod", {bus.hi, bus.lo}, 64'd0);
        resetn = 1'b0;
        step();

        foreach (vecs[i]) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].sgn);
            chk($sformatf("v%0d_busy_after_start", i), 64'(bus.busy), 64'd1);
            wait_done(n, busy_n);
            chk($sformatf("v%0d_latency", i), 64'(n), 64'd33);
            chk($sformatf("v%0d_busy_cycles", i), 64'(busy_n), 64'd32);
            chk($sformatf("v%0d_busy_at_done", i), 64'(bus.busy), 64'd0);
            chk($sformatf("v%0d_hi", i), 64'(bus.hi), 64'(vecs[i].exp_hi));
            chk($sformatf("v%0d_lo", i), 64'(bus.lo), 64'(vecs[i].exp_lo));
            step();
            chk($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'd0);
            chk($sformatf("v%0d_hold", i), {bus.hi, bus.lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
        end

        // Restart at iteration 10 discards the first operation.
        launch(32'd5, 32'd5, 1'b1);
        seen = 0;
        repeat (9) begin
            step();
            if (bus.done === 1'b1) seen++;
        end
        bus.a     = 32'd6;
        bus.b     = 32'd9;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("restart_no_early_done", 64'(seen), 64'd0);
        wait_done(n, busy_n);
        chk("restart_latency", 64'(n), 64'd33);
        chk("restart_prod", {bus.hi, bus.lo}, 64'h0000_0000_0000_0036);
        seen = 0;
        repeat (40) begin
            step();
            if (bus.done === 1'b1) seen++;
        end
        chk("restart_single_done", 64'(seen), 64'd0);

        // Reset at iteration 20 aborts with no later done.
        launch(32'h0000_1234, 32'h0000_5678, 1'b1);
        repeat (19) step();
        resetn = 1'b1;
        step();
        resetn = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_prod", {bus.hi, bus.lo}, 64'd0);
        seen = 0;
        repeat (40) begin
            step();
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        chk("abort_quiet", 64'(seen), 64'd0);

        // Held start keeps restarting; done follows only the final start.
        @(posedge clock);
        #1;
        bus.a     = 32'd11;
        bus.b     = 32'd13;
        bus.start = 1'b1;
        seen = 0;
        repeat (40) begin
            step();
            if (bus.done === 1'b1) seen++;
        end
        bus.start = 1'b0;
        chk("held_start_no_done", 64'(seen), 64'd0);
        wait_done(n, busy_n);
        chk("held_start_latency", 64'(n), 64'd33);
        chk("held_start_prod", {bus.hi, bus.lo}, 64'd143);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
